uart_rx: RTL and testbench

8N1 UART receiver. It is the downstream counterpart of the serial transmitter and consumes the `tx` line that the transmitter drives. It oversamples the asynchronous serial input at the system clock, reconstructs each byte LSB-first and presents it on a one-entry valid/ready output register. It reports framing errors and overruns as single-cycle pulses.

---
 rtl/uart_rx.sv | 170 +++++++++++++++++
 tb/tb_uart_rx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver.
//
// Oversamples the asynchronous serial line at the system clock, rebuilds each
// byte LSB-first and holds it in a one-entry output register until the
// consumer accepts it. Framing errors and overruns are reported as one-cycle
// pulses.
//
// Parameters:
//   clk_per_bit  clock cycles per serial bit (>= 4), must match the sender.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   rx         in   asynchronous serial line, idles high
//   rx_data    out  received byte, valid while rx_valid=1
//   rx_valid   out  byte available, held until accepted
//   rx_ready   in   consumer accepts when rx_valid && rx_ready at a clock edge
//   frame_err  out  one-cycle pulse: stop bit sampled low
//   overrun    out  one-cycle pulse: byte completed while register still full
//   dbg_state  out  receiver state (0 IDLE, 1 START, 2 DATA, 3 STOP, 4 BREAK)
//
// Handshake: rx_valid/rx_data form a valid/ready source. Once rx_valid rises,
// rx_valid stays high and rx_data stays constant until an edge where
// rx_ready=1; rx_valid then falls on that edge unless a new byte loads on the
// same edge. rx_ready has no effect while rx_valid=0.
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int clk_per_bit = 87
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic [2:0] dbg_state
);

  // Counter compare points: end of a full bit, and end of the half-bit wait
  // that moves the sampling point to the middle of the start bit.
  localparam logic [15:0] LAST_CNT  = 16'(clk_per_bit - 1);
  localparam logic [15:0] HALF_LAST = 16'((clk_per_bit / 2) - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  logic        rx_meta_q;
  logic        rx_s_q;
  state_e      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        frame_err_q;
  logic        overrun_q;

  // Two-flop synchronizer; resets to the idle (high) line level so a reset
  // never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      // Acceptance; a delivery later in this block on the same edge wins.
      if (valid_q && rx_ready) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!rx_s_q) begin
            state_q <= S_START;
          end
        end

        S_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            // A line already back high mid-start-bit is a glitch.
            state_q   <= rx_s_q ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        S_DATA: begin
          if (cnt_q == LAST_CNT) begin
            cnt_q              <= '0;
            shift_q[bit_idx_q] <= rx_s_q;
            bit_idx_q          <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        S_STOP: begin
          if (cnt_q == LAST_CNT) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              // Back to IDLE mid-stop-bit; the line is high so no false start.
              state_q <= S_IDLE;
              if (!valid_q || rx_ready) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        S_BREAK: begin
          // Held-low line or break: wait for idle without re-flagging.
          if (rx_s_q) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- directed + randomized bench for uart_rx.
// Frames are driven bit by bit at the serial rate; a monitor records every
// accepted byte and every flag pulse, and the main sequence compares them
// against bytes and timings predicted from the frame format.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CPB = 87;
  localparam int H   = CPB / 2;
  // Edges from the first synchronizer capture of the start bit to the stop
  // sample: 2 sync/detect edges, half a bit, then 9 full bits.
  localparam int STOP_LAT = 2 + H + 9 * CPB;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic [2:0] dbg_state;

  uart_rx #(.clk_per_bit(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / cycle count ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  int fe_cnt       = 0;
  int ov_cnt       = 0;
  int valid_cycles = 0;
  int rise_cyc     = 0;
  int fe_cyc       = 0;
  int ov_cyc       = 0;
  int start_cyc    = 0;

  logic       mon_prev_valid = 1'b0;
  logic       mon_prev_acc   = 1'b0;
  logic [7:0] mon_prev_data  = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      mon_prev_valid = 1'b0;
      mon_prev_acc   = 1'b0;
    end else begin
      // A held, unaccepted byte must stay put.
      if (mon_prev_valid && !mon_prev_acc) begin
        check("hold_valid", {31'd0, rx_valid}, 32'd1);
        check("hold_data", {24'd0, rx_data}, {24'd0, mon_prev_data});
      end
      if (rx_valid) valid_cycles++;
      if (rx_valid && !mon_prev_valid) rise_cyc = cyc;
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) begin
        fe_cnt++;
        fe_cyc = cyc;
      end
      if (overrun) begin
        ov_cnt++;
        ov_cyc = cyc;
      end
      if (frame_err || overrun) check("flag_exclusive", {31'd0, frame_err & overrun}, 32'd0);
      mon_prev_valid = rx_valid;
      mon_prev_acc   = rx_valid && rx_ready;
      mon_prev_data  = rx_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    start_cyc = cyc;
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
    rx = stop_bit;
    repeat (CPB) tick();
  endtask

  // Compare everything accepted so far against the predicted byte stream.
  task automatic check_scoreboard(input string tag);
    int n;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_byte"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int vc0;
    int fe0;
    int ov0;
    int t_b2;
    int t_12;
    logic [7:0] pat [3];
    logic [7:0] rb;

    rx       = 1'b1;
    rx_ready = 1'b0;
    reset    = 1'b1;
    repeat (3) tick();
    check("rst_data", {24'd0, rx_data}, 32'd0);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    reset = 1'b0;
    idle(5);

    // 1: single 0xAB frame, latency and one-cycle valid with ready held high.
    rx_ready = 1'b1;
    vc0 = valid_cycles;
    rise_cyc = 0;
    exp_q.push_back(8'hAB);
    send_frame(8'hAB, 1'b1);
    idle(5);
    check("t1_latency", rise_cyc - (start_cyc + 1), STOP_LAT);
    check("t1_valid_width", valid_cycles - vc0, 32'd1);
    check_scoreboard("t1");

    // 2: back-to-back frames.
    pat[0] = 8'h00;
    pat[1] = 8'hFF;
    pat[2] = 8'h55;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(pat[i]);
      send_frame(pat[i], 1'b1);
    end
    idle(5);
    check_scoreboard("t2");
    check("t2_ferr", fe_cnt, 32'd0);
    check("t2_ovr", ov_cnt, 32'd0);

    // 3: 20-cycle low glitch is shorter than half a bit and must be ignored.
    vc0 = valid_cycles;
    rx = 1'b0;
    repeat (20) tick();
    rx = 1'b1;
    repeat (H + 10) tick();
    check("t3_state_idle", {29'd0, dbg_state}, 32'd0);
    check("t3_no_valid", valid_cycles - vc0, 32'd0);
    check("t3_ferr", fe_cnt, 32'd0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    idle(5);
    check_scoreboard("t3");

    // 4: bad stop bit followed by a held-low line.
    fe0 = fe_cnt;
    send_frame(8'h12, 1'b0);
    t_12 = start_cyc;
    repeat (300) tick();
    check("t4_state_break", {29'd0, dbg_state}, 32'd4);
    check("t4_ferr_once", fe_cnt - fe0, 32'd1);
    check("t4_ferr_time", fe_cyc - (t_12 + 1), STOP_LAT);
    idle(10);
    check("t4_state_idle", {29'd0, dbg_state}, 32'd0);
    exp_q.push_back(8'h34);
    send_frame(8'h34, 1'b1);
    idle(5);
    check("t4_ferr_total", fe_cnt - fe0, 32'd1);
    check_scoreboard("t4");

    // 5: backpressure, second byte overruns and is dropped.
    rx_ready = 1'b0;
    ov0 = ov_cnt;
    fe0 = fe_cnt;
    send_frame(8'hA1, 1'b1);
    idle(3);
    check("t5_valid_a1", {31'd0, rx_valid}, 32'd1);
    check("t5_data_a1", {24'd0, rx_data}, 32'hA1);
    send_frame(8'hB2, 1'b1);
    t_b2 = start_cyc;
    idle(5);
    check("t5_ovr_once", ov_cnt - ov0, 32'd1);
    check("t5_ovr_time", ov_cyc - (t_b2 + 1), STOP_LAT);
    check("t5_no_ferr", fe_cnt - fe0, 32'd0);
    check("t5_data_kept", {24'd0, rx_data}, 32'hA1);
    check("t5_valid_kept", {31'd0, rx_valid}, 32'd1);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("t5_valid_drop", {31'd0, rx_valid}, 32'd0);
    exp_q.push_back(8'hA1);
    check_scoreboard("t5");

    // 6: reset during data bit 6 of 0xC3; the remaining tail is all high.
    rx_ready = 1'b1;
    vc0 = valid_cycles;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    fork
      send_frame(8'hC3, 1'b1);
    join_none
    repeat (7 * CPB + H) tick();
    check("t6_state_data", {29'd0, dbg_state}, 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_data", {24'd0, rx_data}, 32'd0);
    check("t6_rst_valid", {31'd0, rx_valid}, 32'd0);
    check("t6_rst_ferr", {31'd0, frame_err}, 32'd0);
    check("t6_rst_ovr", {31'd0, overrun}, 32'd0);
    check("t6_rst_state", {29'd0, dbg_state}, 32'd0);
    wait fork;
    idle(20);
    check("t6_tail_no_valid", valid_cycles - vc0, 32'd0);
    check("t6_tail_no_ferr", fe_cnt - fe0, 32'd0);
    check("t6_tail_no_ovr", ov_cnt - ov0, 32'd0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    idle(5);
    check_scoreboard("t6");

    // Random bytes with random idle gaps.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom_range(0, 255));
      exp_q.push_back(rb);
      send_frame(rb, 1'b1);
      idle($urandom_range(0, 30));
    end
    idle(5);
    check_scoreboard("rand");
    check("rand_ferr", fe_cnt - fe0, 32'd0);
    check("rand_ovr", ov_cnt - ov0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
